// File: rtl/drive_pkg.sv
// Shared definitions for the motor drive path: steering codes (bit-exact with the
// direction controller), the channel FSM states, default duties and the DIR decoder.
package drive_pkg;

    localparam logic [3:0] DIR_PROCEED      = 4'b0000;
    localparam logic [3:0] DIR_VEER_RIGHT   = 4'b1001;
    localparam logic [3:0] DIR_HARD_RIGHT   = 4'b1010;
    localparam logic [3:0] DIR_NINETY_RIGHT = 4'b1011;
    localparam logic [3:0] DIR_VEER_LEFT    = 4'b0101;
    localparam logic [3:0] DIR_HARD_LEFT    = 4'b0110;
    localparam logic [3:0] DIR_NINETY_LEFT  = 4'b0111;
    localparam logic [3:0] DIR_STOP         = 4'b1111;

    localparam int DEF_PWM_PERIOD = 1000;
    localparam int DEF_DUTY_W     = 10;
    localparam int DEF_RAMP_DIV   = 10_000;
    localparam int DEF_RAMP_STEP  = 5;
    localparam int DEF_DEAD_TIME  = 50_000;
    localparam int DEF_DUTY_FULL   = 900;
    localparam int DEF_DUTY_VEER   = 600;
    localparam int DEF_DUTY_HARD   = 300;
    localparam int DEF_DUTY_NINETY = 700;

    typedef enum logic [1:0] {
        CH_IDLE,
        CH_RUN,
        CH_RAMP_DN,
        CH_DEAD
    } ch_state_e;

    typedef enum logic [2:0] {
        CMD_PROCEED,
        CMD_VEER,
        CMD_HARD,
        CMD_NINETY,
        CMD_STOP
    } steer_cmd_e;

    typedef struct packed {
        steer_cmd_e cmd;
        logic       right;
    } steer_t;

    // Every code not listed, including the unused severities, is treated as STOP.
    function automatic steer_t decode_dir(input logic [3:0] dir);
        steer_t s;
        s.cmd   = CMD_STOP;
        s.right = 1'b0;
        case (dir)
            DIR_PROCEED:      s.cmd = CMD_PROCEED;
            DIR_VEER_RIGHT:   begin s.cmd = CMD_VEER;   s.right = 1'b1; end
            DIR_HARD_RIGHT:   begin s.cmd = CMD_HARD;   s.right = 1'b1; end
            DIR_NINETY_RIGHT: begin s.cmd = CMD_NINETY; s.right = 1'b1; end
            DIR_VEER_LEFT:    s.cmd = CMD_VEER;
            DIR_HARD_LEFT:    s.cmd = CMD_HARD;
            DIR_NINETY_LEFT:  s.cmd = CMD_NINETY;
            default:          s.cmd = CMD_STOP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/motor_channel.sv
// One wheel: duty ramp, reversal FSM with dead-time, and the registered PWM compare
// against the shared frame counter.
module motor_channel
    import drive_pkg::*;
#(
    parameter int DUTY_W    = DEF_DUTY_W,
    parameter int RAMP_STEP = DEF_RAMP_STEP,
    parameter int DEAD_TIME = DEF_DEAD_TIME
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stop,
    input  logic              tick,
    input  logic              wrap,
    input  logic [DUTY_W-1:0] cnt,
    input  logic [DUTY_W:0]   tgt_duty,
    input  logic              tgt_fwd,
    output logic              pwm,
    output logic              fwd
);

    localparam int DEAD_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

    typedef logic [DUTY_W:0]   duty_t;
    typedef logic [DEAD_W-1:0] dead_t;

    localparam duty_t STEP      = duty_t'(RAMP_STEP);
    localparam dead_t DEAD_LOAD = dead_t'(DEAD_TIME);

    ch_state_e state, state_nx;
    duty_t     duty, duty_nx;
    duty_t     active_duty, active_nx;
    duty_t     goal;
    dead_t     dead_cnt, dead_nx;
    logic      fwd_q, fwd_nx;
    logic      pwm_q, pwm_nx;

    // Move cur toward tgt by at most STEP; the clamp to diff prevents overshoot.
    function automatic duty_t step_toward(input duty_t cur, input duty_t tgt);
        duty_t diff;
        if (tgt > cur) begin
            diff = tgt - cur;
            return cur + ((diff > STEP) ? STEP : diff);
        end
        diff = cur - tgt;
        return cur - ((diff > STEP) ? STEP : diff);
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx  = state;
        duty_nx   = duty;
        active_nx = active_duty;
        dead_nx   = dead_cnt;
        fwd_nx    = fwd_q;

        goal = (state == CH_RUN && tgt_fwd == fwd_q) ? tgt_duty : '0;
        if (tick) duty_nx = step_toward(duty, goal);
        // Latching the pre-tick duty at wrap keeps a frame's width fixed once it starts.
        if (wrap) active_nx = duty;
        pwm_nx = (state != CH_DEAD) && ({1'b0, cnt} < active_duty);

        unique case (state)
            CH_IDLE: state_nx = CH_RUN;
            CH_RUN: begin
                if (tgt_fwd != fwd_q) state_nx = CH_RAMP_DN;
            end
            CH_RAMP_DN: begin
                if (tgt_fwd == fwd_q) begin
                    state_nx = CH_RUN;
                end else if (duty == '0 && active_duty == '0) begin
                    state_nx = CH_DEAD;
                    dead_nx  = DEAD_LOAD;
                end
            end
            CH_DEAD: begin
                // Dead-time always runs out; the sense request is looked at again in RUN.
                if (dead_cnt <= dead_t'(1)) begin
                    state_nx = CH_RUN;
                    fwd_nx   = ~fwd_q;
                    dead_nx  = '0;
                end else begin
                    dead_nx = dead_cnt - dead_t'(1);
                end
            end
            default: state_nx = CH_IDLE;
        endcase

        if (stop) begin
            state_nx  = CH_IDLE;
            duty_nx   = '0;
            active_nx = '0;
            dead_nx   = '0;
            pwm_nx    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= CH_IDLE;
            duty        <= '0;
            active_duty <= '0;
            dead_cnt    <= '0;
            fwd_q       <= 1'b1;
            pwm_q       <= 1'b0;
        end else begin
            state       <= state_nx;
            duty        <= duty_nx;
            active_duty <= active_nx;
            dead_cnt    <= dead_nx;
            fwd_q       <= fwd_nx;
            pwm_q       <= pwm_nx;
        end
    end

    // Gating with the registered stop forces the pin low in the first STOP cycle.
    assign pwm = pwm_q & ~stop;
    assign fwd = fwd_q;

endmodule

// File: rtl/motor_drive_ctrl.sv
// Top of the motor drive path: registers the steering inputs, decodes per-wheel targets,
// and shares the PWM frame counter and ramp prescaler between the two wheel channels.
module motor_drive_ctrl
    import drive_pkg::*;
#(
    parameter int PWM_PERIOD  = DEF_PWM_PERIOD,
    parameter int DUTY_W      = DEF_DUTY_W,
    parameter int RAMP_DIV    = DEF_RAMP_DIV,
    parameter int RAMP_STEP   = DEF_RAMP_STEP,
    parameter int DEAD_TIME   = DEF_DEAD_TIME,
    parameter int DUTY_FULL   = DEF_DUTY_FULL,
    parameter int DUTY_VEER   = DEF_DUTY_VEER,
    parameter int DUTY_HARD   = DEF_DUTY_HARD,
    parameter int DUTY_NINETY = DEF_DUTY_NINETY
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] DIR,
    input  logic       Direction,
    output logic       L_PWM,
    output logic       R_PWM,
    output logic       L_FWD,
    output logic       R_FWD,
    output logic       BRAKE
);

    localparam int PRE_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef logic [DUTY_W:0]   duty_t;
    typedef logic [DUTY_W-1:0] cnt_t;
    typedef logic [PRE_W-1:0]  pre_t;

    localparam duty_t D_FULL   = duty_t'(DUTY_FULL);
    localparam duty_t D_VEER   = duty_t'(DUTY_VEER);
    localparam duty_t D_HARD   = duty_t'(DUTY_HARD);
    localparam duty_t D_NINETY = duty_t'(DUTY_NINETY);
    localparam cnt_t  CNT_MAX  = cnt_t'(PWM_PERIOD - 1);
    localparam pre_t  PRE_MAX  = pre_t'(RAMP_DIV - 1);

    logic [3:0] dir_q;
    logic       direction_q;
    steer_t     steer;
    logic       stop;

    duty_t inner_duty, outer_duty;
    logic  inner_fwd;
    duty_t l_duty_tgt, r_duty_tgt;
    logic  l_fwd_tgt, r_fwd_tgt;

    cnt_t  pwm_cnt;
    pre_t  pre_cnt;
    logic  wrap, tick;

    // Reset to the STOP code so BRAKE is asserted straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q       <= DIR_STOP;
            direction_q <= 1'b1;
        end else begin
            dir_q       <= DIR;
            direction_q <= Direction;
        end
    end

    assign steer = decode_dir(dir_q);
    assign stop  = (steer.cmd == CMD_STOP);
    assign BRAKE = stop;

    always_comb begin
        inner_duty = '0;
        outer_duty = '0;
        inner_fwd  = 1'b1;
        case (steer.cmd)
            CMD_PROCEED: begin inner_duty = D_FULL;   outer_duty = D_FULL;   end
            CMD_VEER:    begin inner_duty = D_VEER;   outer_duty = D_FULL;   end
            CMD_HARD:    begin inner_duty = D_HARD;   outer_duty = D_FULL;   end
            CMD_NINETY:  begin inner_duty = D_NINETY; outer_duty = D_NINETY; inner_fwd = 1'b0; end
            default:     ;
        endcase

        // Inner wheel is the one on the turn side; backwards travel flips every sense.
        l_duty_tgt = steer.right ? outer_duty : inner_duty;
        r_duty_tgt = steer.right ? inner_duty : outer_duty;
        l_fwd_tgt  = (steer.right ? 1'b1 : inner_fwd) ^ ~direction_q;
        r_fwd_tgt  = (steer.right ? inner_fwd : 1'b1) ^ ~direction_q;
    end

    assign wrap = (pwm_cnt == CNT_MAX);
    assign tick = (pre_cnt == PRE_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
            pre_cnt <= '0;
        end else begin
            pwm_cnt <= wrap ? '0 : pwm_cnt + cnt_t'(1);
            pre_cnt <= tick ? '0 : pre_cnt + pre_t'(1);
        end
    end

    motor_channel #(
        .DUTY_W   (DUTY_W),
        .RAMP_STEP(RAMP_STEP),
        .DEAD_TIME(DEAD_TIME)
    ) u_left (
        .clk     (clk),
        .rst_n   (rst_n),
        .stop    (stop),
        .tick    (tick),
        .wrap    (wrap),
        .cnt     (pwm_cnt),
        .tgt_duty(l_duty_tgt),
        .tgt_fwd (l_fwd_tgt),
        .pwm     (L_PWM),
        .fwd     (L_FWD)
    );

    motor_channel #(
        .DUTY_W   (DUTY_W),
        .RAMP_STEP(RAMP_STEP),
        .DEAD_TIME(DEAD_TIME)
    ) u_right (
        .clk     (clk),
        .rst_n   (rst_n),
        .stop    (stop),
        .tick    (tick),
        .wrap    (wrap),
        .cnt     (pwm_cnt),
        .tgt_duty(r_duty_tgt),
        .tgt_fwd (r_fwd_tgt),
        .pwm     (R_PWM),
        .fwd     (R_FWD)
    );

endmodule

// File: tb/tb_motor_drive_ctrl.sv
// Self-checking bench for motor_drive_ctrl: directed scenarios, then random steering
// codes, all compared every cycle against a cycle-count based behavioural model.
module tb_motor_drive_ctrl;

    localparam int P       = 10;
    localparam int RD      = 2;
    localparam int STEP    = 2;
    localparam int DEAD_T  = 6;
    localparam int FULL    = 8;
    localparam int VEER    = 6;
    localparam int HARD    = 4;
    localparam int NINETY  = 6;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DOWN = 2;
    localparam int PH_DEAD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] DIR = 4'b0000;
    logic       Direction = 1'b1;
    logic       L_PWM, R_PWM, L_FWD, R_FWD, BRAKE;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    motor_drive_ctrl #(
        .PWM_PERIOD (P),
        .DUTY_W     (4),
        .RAMP_DIV   (RD),
        .RAMP_STEP  (STEP),
        .DEAD_TIME  (DEAD_T),
        .DUTY_FULL  (FULL),
        .DUTY_VEER  (VEER),
        .DUTY_HARD  (HARD),
        .DUTY_NINETY(NINETY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .DIR      (DIR),
        .Direction(Direction),
        .L_PWM    (L_PWM),
        .R_PWM    (R_PWM),
        .L_FWD    (L_FWD),
        .R_FWD    (R_FWD),
        .BRAKE    (BRAKE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Timing is derived from the number of clock edges since reset: frame position is
    // edges mod P, ramp ticks every RD edges, dead-time ends at a fixed edge deadline.
    int         m_edge;
    logic [3:0] m_dir;
    bit         m_direction;
    int         m_ph[2];
    int         m_duty[2];
    int         m_act[2];
    bit         m_fwd[2];
    int         m_deadline[2];
    bit         m_pq[2];

    task automatic target(input logic [3:0] d, input bit dirn, output bit stp,
                          output int tl, output int tr, output bit sl, output bit sr);
        stp = 1'b0; sl = 1'b1; sr = 1'b1; tl = 0; tr = 0;
        case (d)
            4'b0000: begin tl = FULL;   tr = FULL;   end
            4'b1001: begin tl = FULL;   tr = VEER;   end
            4'b1010: begin tl = FULL;   tr = HARD;   end
            4'b1011: begin tl = NINETY; tr = NINETY; sr = 1'b0; end
            4'b0101: begin tl = VEER;   tr = FULL;   end
            4'b0110: begin tl = HARD;   tr = FULL;   end
            4'b0111: begin tl = NINETY; tr = NINETY; sl = 1'b0; end
            default: stp = 1'b1;
        endcase
        if (!dirn) begin sl = !sl; sr = !sr; end
    endtask

    task automatic model_reset();
        m_edge = 0; m_dir = 4'b1111; m_direction = 1'b1;
        for (int w = 0; w < 2; w++) begin
            m_ph[w] = PH_IDLE; m_duty[w] = 0; m_act[w] = 0;
            m_fwd[w] = 1'b1; m_deadline[w] = 0; m_pq[w] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit stp, wrap, tick;
        int td[2];
        bit ts[2];
        int c, pos, goal, mv, old_duty, old_act;
        c    = m_edge;
        pos  = c % P;
        wrap = (pos == P - 1);
        tick = ((c % RD) == RD - 1);
        target(m_dir, m_direction, stp, td[0], td[1], ts[0], ts[1]);
        for (int w = 0; w < 2; w++) begin
            if (stp) begin
                m_ph[w] = PH_IDLE; m_duty[w] = 0; m_act[w] = 0; m_pq[w] = 1'b0;
            end else begin
                old_duty = m_duty[w];
                old_act  = m_act[w];
                m_pq[w]  = (m_ph[w] != PH_DEAD) && (pos < old_act);
                goal = (m_ph[w] == PH_RUN && ts[w] == m_fwd[w]) ? td[w] : 0;
                if (tick) begin
                    mv = goal - old_duty;
                    if (mv > STEP) mv = STEP;
                    if (mv < -STEP) mv = -STEP;
                    m_duty[w] = old_duty + mv;
                end
                if (wrap) m_act[w] = old_duty;
                case (m_ph[w])
                    PH_IDLE: m_ph[w] = PH_RUN;
                    PH_RUN:  if (ts[w] != m_fwd[w]) m_ph[w] = PH_DOWN;
                    PH_DOWN: begin
                        if (ts[w] == m_fwd[w]) m_ph[w] = PH_RUN;
                        else if (old_duty == 0 && old_act == 0) begin
                            m_ph[w] = PH_DEAD;
                            m_deadline[w] = c + DEAD_T;
                        end
                    end
                    default: if (c >= m_deadline[w]) begin
                        m_ph[w]  = PH_RUN;
                        m_fwd[w] = !m_fwd[w];
                    end
                endcase
            end
        end
        m_dir = DIR;
        m_direction = Direction;
        m_edge++;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Per-cycle comparison of {BRAKE, L_PWM, R_PWM, L_FWD, R_FWD} against the model.
    always @(negedge clk) begin
        bit stp, sl, sr;
        int tl, tr;
        if (cmp_en) begin
            target(m_dir, m_direction, stp, tl, tr, sl, sr);
            check("outputs", {27'd0, BRAKE, L_PWM, R_PWM, L_FWD, R_FWD},
                  {27'd0, stp, m_pq[0] & !stp, m_pq[1] & !stp, m_fwd[0], m_fwd[1]});
        end
    end

    // ---------------- helpers ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(output int lh, output int rh);
        lh = 0; rh = 0;
        repeat (P) begin
            @(negedge clk);
            lh += int'(L_PWM);
            rh += int'(R_PWM);
        end
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int lh, rh, k, low_run, last;
        bit flipped;
        int seq[$];
        logic [3:0] codes[16];

        // Reset values
        repeat (2) @(negedge clk);
        check("reset_outputs", {BRAKE, L_PWM, R_PWM, L_FWD, R_FWD}, 5'b10011);
        cmp_en = 1'b1;

        // 1. Release with PROCEED forwards
        DIR = 4'b0000; Direction = 1'b1; rst_n = 1'b1;
        @(negedge clk);
        check("t1_brake_falls", BRAKE, 1'b0);
        last = 0;
        repeat (40) begin
            @(negedge clk);
            if (m_duty[0] != last) begin seq.push_back(m_duty[0]); last = m_duty[0]; end
        end
        check("t1_ramp_len", seq.size(), 4);
        for (int i = 0; i < seq.size() && i < 4; i++)
            check("t1_ramp_step", seq[i], 2 * (i + 1));
        count_high(lh, rh);
        check("t1_l_high", lh, FULL);
        check("t1_r_high", rh, FULL);
        check("t1_fwd", {L_FWD, R_FWD}, 2'b11);

        // 2. Veer right
        DIR = 4'b1001;
        cycles(40);
        count_high(lh, rh);
        check("t2_l_high", lh, FULL);
        check("t2_r_high", rh, VEER);
        check("t2_fwd", {L_FWD, R_FWD}, 2'b11);

        // 3. Ninety right from steady PROCEED
        DIR = 4'b0000;
        cycles(40);
        DIR = 4'b1011;
        low_run = 0; flipped = 1'b0; k = 0;
        while (!flipped && k < 300) begin
            @(negedge clk); k++;
            if (R_FWD !== 1'b1) begin
                flipped = 1'b1;
                check("t3_dead_low_run", low_run >= DEAD_T, 1);
            end else begin
                low_run = R_PWM ? 0 : low_run + 1;
            end
        end
        check("t3_r_flip_seen", flipped, 1'b1);
        cycles(60);
        count_high(lh, rh);
        check("t3_l_high", lh, NINETY);
        check("t3_r_high", rh, NINETY);
        check("t3_fwd", {L_FWD, R_FWD}, 2'b10);

        // 4. STOP mid-ramp, then restart
        DIR = 4'b1111;
        cycles(5);
        DIR = 4'b0000;
        k = 0;
        while (m_duty[0] != 4 && k < 200) begin @(negedge clk); k++; end
        check("t4_mid_ramp_reached", k < 200, 1);
        DIR = 4'b1111;
        @(negedge clk);
        check("t4_stop_next_cycle", {BRAKE, L_PWM, R_PWM}, 3'b100);
        cycles(10);
        DIR = 4'b0000;
        @(negedge clk);
        check("t4_brake_release", BRAKE, 1'b0);
        cycles(60);
        count_high(lh, rh);
        check("t4_l_high", lh, FULL);
        check("t4_r_high", rh, FULL);

        // 5. Reverse travel
        Direction = 1'b0;
        cycles(150);
        check("t5_fwd", {L_FWD, R_FWD}, 2'b00);
        count_high(lh, rh);
        check("t5_l_high", lh, FULL);
        check("t5_r_high", rh, FULL);

        // 6. Reset during DEAD, then undefined code behaves as STOP
        Direction = 1'b1;
        k = 0;
        while (m_ph[0] != PH_DEAD && k < 200) begin @(negedge clk); k++; end
        check("t6_dead_reached", k < 200, 1);
        #2 rst_n = 1'b0;
        #1 check("t6_async_reset", {BRAKE, L_PWM, R_PWM, L_FWD, R_FWD}, 5'b10011);
        @(negedge clk);
        DIR = 4'b0001;
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            check("t6_undefined_is_stop", {BRAKE, L_PWM, R_PWM}, 3'b100);
        end

        // Random phase
        codes = '{4'b0000, 4'b1001, 4'b1010, 4'b1011, 4'b0101, 4'b0110, 4'b0111, 4'b1111,
                  4'b0000, 4'b1001, 4'b0101, 4'b1011, 4'b0111, 4'b0001, 4'b1000, 4'b1100};
        for (int s = 0; s < 50; s++) begin
            DIR = codes[$urandom_range(0, 15)];
            Direction = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycles($urandom_range(5, 120));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
